// File: rtl/bus_arbiter2_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package bus_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mux2to1.sv
// Plain 2:1 payload multiplexer; switch=0 selects a, switch=1 selects b.
module mux2to1 #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            switch,
  output logic [SIZE-1:0] y
);

  assign y = switch ? b : a;

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin arbiter sharing one SIZE-bit port between two requesters, with a beat quota.
// Grant 1 cycle after request, zero-bubble handoff; out_ready only gates beat counting.
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int SIZE     = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic [SIZE-1:0] data0,
  input  logic            req1,
  input  logic [SIZE-1:0] data1,
  input  logic            out_ready,
  output logic            gnt0,
  output logic            gnt1,
  output logic            sel,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          prio, prio_nxt;
  logic          sel_nxt;
  logic          beat;
  logic          owner_req, other_req, other_idx;
  logic          enter;
  logic          who;

  assign gnt0      = (state == OWN0);
  assign gnt1      = (state == OWN1);
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign beat      = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prio_nxt  = prio;
    sel_nxt   = sel;
    enter     = 1'b0;
    who       = REQ0;
    owner_req = (state == OWN1) ? req1 : req0;
    other_req = (state == OWN1) ? req0 : req1;
    other_idx = (state == OWN1) ? REQ0 : REQ1;

    case (state)
      IDLE: begin
        if (req0 && (!req1 || prio == REQ0)) begin
          enter = 1'b1;
          who   = REQ0;
        end else if (req1) begin
          enter = 1'b1;
          who   = REQ1;
        end
      end
      OWN0, OWN1: begin
        if (!owner_req) begin
          if (other_req) begin
            enter = 1'b1;
            who   = other_idx;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (beat) begin
          // Quota reached: hand over if the other side waits, else start a fresh quota.
          if (cnt == LAST) begin
            cnt_nxt = '0;
            if (other_req) begin
              enter = 1'b1;
              who   = other_idx;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (enter) begin
      state_nxt = (who == REQ1) ? OWN1 : OWN0;
      sel_nxt   = who;
      prio_nxt  = ~who;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      prio  <= REQ0;
      sel   <= REQ0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prio  <= prio_nxt;
      sel   <= sel_nxt;
    end
  end

  mux2to1 #(.SIZE(SIZE)) u_mux (
    .a      (data0),
    .b      (data1),
    .switch (sel),
    .y      (out_data)
  );

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed and randomized checks of bus_arbiter2 against an ownership-level reference model.
module tb_bus_arbiter2;

  localparam int SIZE     = 16;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0, req1, out_ready;
  logic [SIZE-1:0] data0, data1;
  logic            gnt0, gnt1, sel, out_valid;
  logic [SIZE-1:0] out_data;

  int   vectors    = 0;
  int   miscompares = 0;
  bit   armed      = 1'b0;

  // Reference model: who owns the port (-1 none), beats taken in this quota, tie-break pointer.
  int   m_own  = -1;
  int   m_cnt  = 0;
  int   m_prio = 0;
  logic m_sel  = 1'b0;

  bus_arbiter2 #(.SIZE(SIZE), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .out_ready (out_ready),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_enter(input int w);
    m_own  = w;
    m_sel  = (w == 1);
    m_prio = 1 - w;
    m_cnt  = 0;
  endtask

  task automatic cycle(input logic r0, input logic [SIZE-1:0] d0, input logic r1,
                       input logic [SIZE-1:0] d1, input logic rdy, input logic rst);
    logic rq[2];
    logic exp_vld;
    req0 = r0; data0 = d0; req1 = r1; data1 = d1; out_ready = rdy; rst_n = rst;
    rq[0] = r0;
    rq[1] = r1;
    #1;
    exp_vld = (m_own >= 0) && rq[m_own];
    if (armed) begin
      chk("gnt0", gnt0, m_own == 0);
      chk("gnt1", gnt1, m_own == 1);
      chk("sel", sel, m_sel);
      chk("out_valid", out_valid, exp_vld);
      chk("out_data", out_data, m_sel ? d1 : d0);
    end
    @(posedge clk);
    if (!rst) begin
      m_own = -1; m_cnt = 0; m_prio = 0; m_sel = 1'b0;
      armed = 1'b1;
    end else if (m_own < 0) begin
      if (r0 && r1)  model_enter(m_prio);
      else if (r0)   model_enter(0);
      else if (r1)   model_enter(1);
    end else if (!rq[m_own]) begin
      if (rq[1 - m_own]) model_enter(1 - m_own);
      else begin m_own = -1; m_cnt = 0; end
    end else if (exp_vld && rdy) begin
      m_cnt++;
      if (m_cnt == MAX_HOLD) begin
        if (rq[1 - m_own]) model_enter(1 - m_own);
        else m_cnt = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [SIZE-1:0] rd0, rd1;

    // Reset held 2 cycles with both requesting.
    cycle(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b0);
    cycle(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_sel", sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 16'h1111);
    cycle(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b1);
    chk("first_gnt0", gnt0, 1);
    chk("first_sel", sel, 0);

    // Single requester streams 10 beats.
    do_reset();
    cycle(1'b1, 16'hA5A5, 1'b0, 16'h5A5A, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("single_gnt0", gnt0, 1);
      chk("single_gnt1", gnt1, 0);
      chk("single_vld", out_valid, 1);
      chk("single_dat", out_data, 16'hA5A5);
      cycle(1'b1, 16'hA5A5, 1'b0, 16'h5A5A, 1'b1, 1'b1);
    end

    // Contention: quota of 4 alternates owners with no bubble.
    do_reset();
    cycle(1'b1, 16'hD000, 1'b1, 16'hD111, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("cont_sel", sel, (i / 4) % 2);
      chk("cont_vld", out_valid, 1);
      chk("cont_dat", out_data, ((i / 4) % 2) ? 16'hD111 : 16'hD000);
      cycle(1'b1, 16'hD000, 1'b1, 16'hD111, 1'b1, 1'b1);
    end

    // Backpressure after 2 beats holds everything.
    do_reset();
    cycle(1'b1, 16'hB0B0, 1'b0, 16'hB1B1, 1'b1, 1'b1);
    cycle(1'b1, 16'hB0B0, 1'b0, 16'hB1B1, 1'b1, 1'b1);
    cycle(1'b1, 16'hB0B0, 1'b0, 16'hB1B1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'hB0B0, 1'b1, 16'hB1B1, 1'b0, 1'b1);
      chk("bp_gnt0", gnt0, 1);
      chk("bp_dat", out_data, 16'hB0B0);
    end
    cycle(1'b1, 16'hB0B0, 1'b1, 16'hB1B1, 1'b1, 1'b1);
    chk("bp_still_gnt0", gnt0, 1);
    cycle(1'b1, 16'hB0B0, 1'b1, 16'hB1B1, 1'b1, 1'b1);
    chk("bp_gnt1", gnt1, 1);
    chk("bp_sel", sel, 1);

    // Owner drops as the other raises: direct handoff.
    do_reset();
    cycle(1'b1, 16'hC0C0, 1'b0, 16'h0000, 1'b1, 1'b1);
    cycle(1'b1, 16'hC0C0, 1'b0, 16'h0000, 1'b1, 1'b1);
    cycle(1'b0, 16'hC0C0, 1'b1, 16'h1234, 1'b1, 1'b1);
    chk("ho_gnt1", gnt1, 1);
    chk("ho_gnt0", gnt0, 0);
    chk("ho_sel", sel, 1);
    chk("ho_dat", out_data, 16'h1234);

    // Reset mid-burst in OWN1 restores prio to requester 0.
    do_reset();
    cycle(1'b0, 16'h0E0E, 1'b1, 16'hE1E1, 1'b1, 1'b1);
    cycle(1'b0, 16'h0E0E, 1'b1, 16'hE1E1, 1'b1, 1'b1);
    cycle(1'b0, 16'h0E0E, 1'b1, 16'hE1E1, 1'b1, 1'b1);
    cycle(1'b0, 16'h0E0E, 1'b1, 16'hE1E1, 1'b1, 1'b0);
    chk("mid_rst_gnt1", gnt1, 0);
    cycle(1'b1, 16'h0E0E, 1'b1, 16'hE1E1, 1'b1, 1'b1);
    chk("mid_rst_gnt0", gnt0, 1);
    chk("mid_rst_sel", sel, 0);

    // Randomized traffic, backpressure and occasional reset.
    for (int i = 0; i < 800; i++) begin
      rd0 = 16'($urandom);
      rd1 = 16'($urandom);
      cycle($urandom_range(0, 3) != 0, rd0, $urandom_range(0, 3) != 0, rd1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
